mp_arith_ctrl: RTL

MP_ARITH_CTRL -- requirements
Module: mp_arith_ctrl

---
 rtl/mp_arith_ctrl.sv | 150 +++++++++++++++
 1 files changed

// File: rtl/mp_arith_ctrl.sv
// Multi-word add/subtract sequencer: one 16-bit word per cycle,
// LS word first, through a single shared 16-bit adder.
module mp_arith_ctrl #(
  parameter int NWORDS = 4
) (
  input  logic                 clk,
  input  logic                 rst_n,
  input  logic                 start,
  input  logic [1:0]           op,
  input  logic                 cin,
  input  logic [16*NWORDS-1:0] a,
  input  logic [16*NWORDS-1:0] b,
  input  logic                 abort,
  output logic [16*NWORDS-1:0] result,
  output logic                 z,
  output logic                 n,
  output logic                 c,
  output logic                 v,
  output logic                 busy,
  output logic                 done
);

  localparam int IW = (NWORDS > 1) ? $clog2(NWORDS) : 1;
  localparam logic [IW-1:0] LAST = IW'(NWORDS - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t state;

  logic [NWORDS-1:0][15:0] a_q;
  logic [NWORDS-1:0][15:0] b_q;
  logic [NWORDS-1:0][15:0] res_q;
  logic [1:0]              op_q;
  logic                    cin_q;
  logic [IW-1:0]           idx;
  logic                    carry;
  logic                    zacc;

  logic [15:0] a_w;
  logic [15:0] b_w;
  logic [15:0] bp_w;
  logic        k0;
  logic        k;
  logic [16:0] sum17;
  logic [15:0] sum;
  logic        co;
  logic        ovf;
  logic        wz;

  assign result = res_q;

  // Word-0 carry-in; SUB is A + ~B + 1
  always_comb begin
    k0 = 1'b0;
    unique case (op_q)
      2'b00:   k0 = 1'b0;
      2'b01:   k0 = cin_q;
      2'b10:   k0 = 1'b1;
      default: k0 = cin_q;
    endcase
  end

  always_comb begin
    a_w   = a_q[idx];
    b_w   = b_q[idx];
    bp_w  = op_q[1] ? ~b_w : b_w;
    k     = (idx == '0) ? k0 : carry;
    sum17 = {1'b0, a_w} + {1'b0, bp_w}
          + {16'd0, k};
    sum   = sum17[15:0];
    co    = sum17[16];
    ovf   = (a_w[15] == bp_w[15])
          & (sum[15] != a_w[15]);
    wz    = (sum == 16'd0);
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state <= IDLE;
      a_q   <= '0;
      b_q   <= '0;
      res_q <= '0;
      op_q  <= 2'b00;
      cin_q <= 1'b0;
      idx   <= '0;
      carry <= 1'b0;
      zacc  <= 1'b0;
      z     <= 1'b0;
      n     <= 1'b0;
      c     <= 1'b0;
      v     <= 1'b0;
      busy  <= 1'b0;
      done  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          done <= 1'b0;
          if (start) begin
            op_q  <= op;
            cin_q <= cin;
            a_q   <= a;
            b_q   <= b;
            idx   <= '0;
            carry <= 1'b0;
            zacc  <= 1'b1;
            res_q <= '0;
            busy  <= 1'b1;
            state <= RUN;
          end
        end
        RUN: begin
          if (abort) begin
            busy  <= 1'b0;
            idx   <= '0;
            state <= IDLE;
          end else begin
            res_q[idx] <= sum;
            carry      <= co;
            zacc       <= zacc & wz;
            idx        <= idx + 1'b1;
            if (idx == LAST) begin
              c     <= co;
              v     <= ovf;
              n     <= sum[15];
              z     <= zacc & wz;
              idx   <= '0;
              busy  <= 1'b0;
              done  <= 1'b1;
              state <= DONE;
            end
          end
        end
        DONE: begin
          done  <= 1'b0;
          state <= IDLE;
        end
        default: begin
          busy  <= 1'b0;
          done  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule
